// File: rtl/pc_if.sv
// Control/status bundle between the IF-stage sequencer and the program-counter unit.
// The master side drives the redirect/call/return/hazard controls; the PC unit is the slave.
interface pc_if #(
  parameter int PC_WIDTH = 16
);
  logic                halt;
  logic                resume;
  logic                stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                call;
  logic                ret;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] prev_pc;
  logic                halted;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_overflow;
  logic                ras_underflow;

  modport master (
    output halt, resume, stall, redirect_valid, redirect_pc, call, ret,
    input  pc, prev_pc, halted, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  halt, resume, stall, redirect_valid, redirect_pc, call, ret,
    output pc, prev_pc, halted, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// IF-stage program counter: sequential fetch, redirect, call/return through a
// circular return-address stack, stall hold and a sticky halt with explicit resume.
module pc_unit #(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  PC_INC       = 1,
  parameter int                  RAS_DEPTH    = 4
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);

  localparam int                  PTR_W = $clog2(RAS_DEPTH);
  localparam int                  CNT_W = PTR_W + 1;
  localparam logic [PC_WIDTH-1:0] INC   = PC_WIDTH'(PC_INC);

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] prev_q, prev_d;
  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    sp_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q;
  logic                unf_q, unf_d;
  logic                push, pop;
  logic                ras_empty, ras_full;
  logic [PC_WIDTH-1:0] ras_top;

  // Truncating increment: the PC and pushed return addresses wrap at PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_wrap_inc(input logic [PC_WIDTH-1:0] v);
    return v + INC;
  endfunction

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  // sp points at the next free slot, so the top is one below it.
  assign ras_top   = ras_mem[sp_q - PTR_W'(1)];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    prev_d  = prev_q;
    push    = 1'b0;
    pop     = 1'b0;
    unf_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else if (bus.redirect_valid) begin
          pc_d   = bus.redirect_pc;
          prev_d = pc_q;
          push   = bus.call;
        end else if (bus.ret) begin
          if (ras_empty) begin
            unf_d = 1'b1;
          end else begin
            pop    = 1'b1;
            pc_d   = ras_top;
            prev_d = pc_q;
          end
        end else if (!bus.stall) begin
          pc_d   = pc_wrap_inc(pc_q);
          prev_d = pc_q;
        end
      end
      HALTED: begin
        if (bus.resume && !bus.halt) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // ---- control / architectural state register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      prev_q  <= RESET_VECTOR;
      sp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      prev_q  <= prev_d;
      unf_q   <= unf_d;
      if (push) begin
        sp_q <= sp_q + PTR_W'(1);
        // A push while full overwrites the oldest entry; depth saturates.
        if (ras_full) ovf_q <= 1'b1;
        else          cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop) begin
        sp_q  <= sp_q - PTR_W'(1);
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // ---- RAS storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (rst && push) ras_mem[sp_q] <= pc_wrap_inc(pc_q);
  end

  assign bus.pc            = pc_q;
  assign bus.prev_pc       = prev_q;
  assign bus.halted        = (state_q == HALTED);
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (RESET_VECTOR=0x0010, PC_INC=1, RAS_DEPTH=4).
module tb_pc_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pc_if #(.PC_WIDTH(16)) bus ();

  pc_unit #(
    .PC_WIDTH    (16),
    .RESET_VECTOR(16'h0010),
    .PC_INC      (1),
    .RAS_DEPTH   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic idle();
    bus.halt = 0; bus.resume = 0; bus.stall = 0; bus.redirect_valid = 0;
    bus.redirect_pc = 16'h0000; bus.call = 0; bus.ret = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [15:0] target);
    idle(); bus.redirect_valid = 1; bus.redirect_pc = target; step(); idle();
  endtask

  task automatic test_reset();
    idle(); rst = 0; step(); step();
    tests++; if (bus.pc !== 16'h0010) begin fails++; $display("FAIL reset_pc got %h exp %h", bus.pc, 16'h0010); end
    tests++; if (bus.prev_pc !== 16'h0010) begin fails++; $display("FAIL reset_prev got %h exp %h", bus.prev_pc, 16'h0010); end
    tests++; if ({bus.halted, bus.ras_empty, bus.ras_full, bus.ras_overflow, bus.ras_underflow} !== 5'b01000)
      begin fails++; $display("FAIL reset_flags got %b exp %b", {bus.halted, bus.ras_empty, bus.ras_full, bus.ras_overflow, bus.ras_underflow}, 5'b01000); end
    rst = 1;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc;
    exp_pc = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (bus.pc !== exp_pc + 16'h1) begin fails++; $display("FAIL seq_pc[%0d] got %h exp %h", i, bus.pc, exp_pc + 16'h1); end
      tests++; if (bus.prev_pc !== exp_pc) begin fails++; $display("FAIL seq_prev[%0d] got %h exp %h", i, bus.prev_pc, exp_pc); end
      exp_pc = exp_pc + 16'h1;
    end
  endtask

  task automatic test_stall();
    jump(16'h0020);
    tests++; if (bus.prev_pc !== 16'h0013) begin fails++; $display("FAIL jump_prev got %h exp %h", bus.prev_pc, 16'h0013); end
    bus.stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if (bus.pc !== 16'h0020) begin fails++; $display("FAIL stall_pc[%0d] got %h exp %h", i, bus.pc, 16'h0020); end
    end
    tests++; if (bus.prev_pc !== 16'h0013) begin fails++; $display("FAIL stall_prev got %h exp %h", bus.prev_pc, 16'h0013); end
    bus.redirect_valid = 1; bus.redirect_pc = 16'h0040; step(); idle();
    tests++; if (bus.pc !== 16'h0040) begin fails++; $display("FAIL stall_redirect_pc got %h exp %h", bus.pc, 16'h0040); end
    tests++; if (bus.prev_pc !== 16'h0020) begin fails++; $display("FAIL stall_redirect_prev got %h exp %h", bus.prev_pc, 16'h0020); end
  endtask

  task automatic test_call_ret();
    jump(16'h0005);
    bus.redirect_valid = 1; bus.redirect_pc = 16'h0100; bus.call = 1; step(); idle();
    tests++; if (bus.pc !== 16'h0100) begin fails++; $display("FAIL call_pc got %h exp %h", bus.pc, 16'h0100); end
    tests++; if (bus.ras_empty !== 1'b0) begin fails++; $display("FAIL call_empty got %b exp %b", bus.ras_empty, 1'b0); end
    bus.ret = 1; step(); idle();
    tests++; if (bus.pc !== 16'h0006) begin fails++; $display("FAIL ret_pc got %h exp %h", bus.pc, 16'h0006); end
    tests++; if (bus.prev_pc !== 16'h0100) begin fails++; $display("FAIL ret_prev got %h exp %h", bus.prev_pc, 16'h0100); end
    tests++; if (bus.ras_empty !== 1'b1) begin fails++; $display("FAIL ret_empty got %b exp %b", bus.ras_empty, 1'b1); end
  endtask

  task automatic test_priority();
    // call without redirect is a plain increment and pushes nothing
    jump(16'h0070);
    bus.call = 1; step(); idle();
    tests++; if (bus.pc !== 16'h0071) begin fails++; $display("FAIL lone_call_pc got %h exp %h", bus.pc, 16'h0071); end
    tests++; if (bus.ras_empty !== 1'b1) begin fails++; $display("FAIL lone_call_empty got %b exp %b", bus.ras_empty, 1'b1); end
    // push one, then ret together with redirect: redirect wins, no pop
    bus.redirect_valid = 1; bus.redirect_pc = 16'h0080; bus.call = 1; step(); idle();
    bus.redirect_valid = 1; bus.redirect_pc = 16'h0090; bus.ret = 1; step(); idle();
    tests++; if (bus.pc !== 16'h0090) begin fails++; $display("FAIL ret_redirect_pc got %h exp %h", bus.pc, 16'h0090); end
    tests++; if (bus.ras_empty !== 1'b0) begin fails++; $display("FAIL ret_redirect_empty got %b exp %b", bus.ras_empty, 1'b0); end
    // ret beats stall
    bus.ret = 1; bus.stall = 1; step(); idle();
    tests++; if (bus.pc !== 16'h0072) begin fails++; $display("FAIL ret_stall_pc got %h exp %h", bus.pc, 16'h0072); end
  endtask

  task automatic test_ras_overflow();
    logic [15:0] tgt;
    jump(16'h0200);
    tgt = 16'h0210;
    for (int i = 0; i < 5; i++) begin
      bus.redirect_valid = 1; bus.redirect_pc = tgt; bus.call = 1; step(); idle();
      if (i == 3) begin
        tests++; if ({bus.ras_full, bus.ras_overflow} !== 2'b10) begin fails++; $display("FAIL ras_fill4 full/ovf got %b exp %b", {bus.ras_full, bus.ras_overflow}, 2'b10); end
      end
      tgt = tgt + 16'h0010;
    end
    tests++; if ({bus.ras_full, bus.ras_overflow} !== 2'b11) begin fails++; $display("FAIL ras_fill5 full/ovf got %b exp %b", {bus.ras_full, bus.ras_overflow}, 2'b11); end
    // oldest (0x0201) was overwritten; remaining entries return newest first
    tgt = 16'h0241;
    for (int i = 0; i < 4; i++) begin
      bus.ret = 1; step(); idle();
      tests++; if (bus.pc !== tgt) begin fails++; $display("FAIL ras_pop[%0d] got %h exp %h", i, bus.pc, tgt); end
      tgt = tgt - 16'h0010;
    end
    tests++; if ({bus.ras_empty, bus.ras_overflow} !== 2'b11) begin fails++; $display("FAIL ras_drained empty/ovf got %b exp %b", {bus.ras_empty, bus.ras_overflow}, 2'b11); end
    bus.ret = 1; step(); idle();
    tests++; if (bus.pc !== 16'h0211) begin fails++; $display("FAIL underflow_pc got %h exp %h", bus.pc, 16'h0211); end
    tests++; if (bus.ras_underflow !== 1'b1) begin fails++; $display("FAIL underflow_pulse got %b exp %b", bus.ras_underflow, 1'b1); end
    step();
    tests++; if (bus.ras_underflow !== 1'b0) begin fails++; $display("FAIL underflow_clear got %b exp %b", bus.ras_underflow, 1'b0); end
    tests++; if (bus.pc !== 16'h0212) begin fails++; $display("FAIL after_underflow_pc got %h exp %h", bus.pc, 16'h0212); end
    tests++; if (bus.ras_overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp %b", bus.ras_overflow, 1'b1); end
  endtask

  task automatic test_halt();
    jump(16'h0030);
    bus.halt = 1; step(); idle();
    tests++; if ({bus.halted, bus.pc} !== {1'b1, 16'h0030}) begin fails++; $display("FAIL halt_enter got %b/%h exp 1/0030", bus.halted, bus.pc); end
    bus.redirect_valid = 1; bus.redirect_pc = 16'h0050; bus.stall = 1; bus.ret = 1; step(); step(); idle();
    tests++; if ({bus.halted, bus.pc} !== {1'b1, 16'h0030}) begin fails++; $display("FAIL halt_frozen got %b/%h exp 1/0030", bus.halted, bus.pc); end
    tests++; if (bus.ras_underflow !== 1'b0) begin fails++; $display("FAIL halt_ret_ignored got %b exp %b", bus.ras_underflow, 1'b0); end
    bus.resume = 1; step(); idle();
    tests++; if ({bus.halted, bus.pc} !== {1'b0, 16'h0030}) begin fails++; $display("FAIL resume got %b/%h exp 0/0030", bus.halted, bus.pc); end
    step();
    tests++; if (bus.pc !== 16'h0031) begin fails++; $display("FAIL resume_seq got %h exp %h", bus.pc, 16'h0031); end
  endtask

  task automatic test_wrap_and_reset();
    jump(16'hFFFF);
    step();
    tests++; if (bus.pc !== 16'h0000) begin fails++; $display("FAIL wrap_pc got %h exp %h", bus.pc, 16'h0000); end
    tests++; if (bus.prev_pc !== 16'hFFFF) begin fails++; $display("FAIL wrap_prev got %h exp %h", bus.prev_pc, 16'hFFFF); end
    bus.halt = 1; step();
    tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL prereset_halted got %b exp %b", bus.halted, 1'b1); end
    rst = 0; bus.stall = 1; step(); idle(); rst = 1;
    tests++; if ({bus.halted, bus.pc, bus.ras_overflow} !== {1'b0, 16'h0010, 1'b0}) begin fails++; $display("FAIL reset_mid_halt got %b/%h/%b exp 0/0010/0", bus.halted, bus.pc, bus.ras_overflow); end
    step();
    tests++; if (bus.pc !== 16'h0011) begin fails++; $display("FAIL post_reset_seq got %h exp %h", bus.pc, 16'h0011); end
  endtask

  initial begin
    idle();
    test_reset();
    test_sequential();
    test_stall();
    test_call_ret();
    test_priority();
    test_ras_overflow();
    test_halt();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
